// File: rtl/reflex_round_ctrl_pkg.sv
// ============================================================================
// Package  : reflex_round_ctrl_pkg
// Brief    : State encodings, default constants and LFSR step for the round controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

package reflex_round_ctrl_pkg;

    localparam logic [2:0] C_ST_IDLE   = 3'd0;
    localparam logic [2:0] C_ST_WAIT   = 3'd1;
    localparam logic [2:0] C_ST_PROMPT = 3'd2;
    localparam logic [2:0] C_ST_CHECK  = 3'd3;
    localparam logic [2:0] C_ST_DONE   = 3'd4;

    localparam int unsigned C_TICK_CYCLES = 75_000_000;
    localparam logic [7:0]  C_LFSR_SEED   = 8'hA5;

    // Fibonacci form of x^8 + x^6 + x^5 + x^4 + 1
    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/reflex_round_ctrl_tick_gen.sv
// ============================================================================
// Module   : reflex_tick_gen
// Brief    : Free-running tick divider with enable and synchronous clear.
// Revision : 1.0
// ============================================================================
`default_nettype none

module reflex_tick_gen
    import reflex_round_ctrl_pkg::*;
#(
    parameter int unsigned TICK_CYCLES = C_TICK_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned     C_CW   = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [C_CW-1:0] C_TERM = C_CW'(TICK_CYCLES - 1);

    logic [C_CW-1:0] r_cnt_q;
    logic [C_CW-1:0] w_cnt_d;

    always_comb begin
        w_cnt_d = r_cnt_q;
        tick    = en && (r_cnt_q == C_TERM);
        if (clr) begin
            w_cnt_d = '0;
        end else if (en) begin
            w_cnt_d = (r_cnt_q == C_TERM) ? '0 : r_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt_q <= '0;
        end else begin
            r_cnt_q <= w_cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/reflex_round_ctrl.sv
// ============================================================================
// Module   : reflex_round_ctrl
// Brief    : NinjaReflex game sequencer: delay, prompt, judge key, tally score.
// Revision : 1.0
// ============================================================================
`default_nettype none

module reflex_round_ctrl
    import reflex_round_ctrl_pkg::*;
#(
    parameter int unsigned TICK_CYCLES = C_TICK_CYCLES,
    parameter int unsigned WAIT_TICKS  = 2,
    parameter int unsigned RESP_TICKS  = 1,
    parameter int unsigned MAX_ROUNDS  = 15,
    parameter int unsigned MAX_WRONG   = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       switch,
    input  logic       start,
    input  logic [3:0] key,
    output logic [3:0] target,
    output logic       prompt_on,
    output logic [4:0] score,
    output logic [2:0] wrong_time,
    output logic [4:0] round,
    output logic       game_over
);

    localparam logic [7:0] C_WAIT_T = 8'(WAIT_TICKS);
    localparam logic [7:0] C_RESP_T = 8'(RESP_TICKS);
    localparam logic [4:0] C_MAX_R  = 5'(MAX_ROUNDS);
    localparam logic [2:0] C_MAX_W  = 3'(MAX_WRONG);

    logic [2:0] r_state_q,  w_state_d;
    logic [7:0] r_lfsr_q;
    logic [3:0] r_target_q, w_target_d;
    logic [4:0] r_score_q,  w_score_d;
    logic [2:0] r_wrong_q,  w_wrong_d;
    logic [4:0] r_round_q,  w_round_d;
    logic [7:0] r_ticks_q,  w_ticks_d;
    logic       w_tick;
    logic       w_tick_en;
    logic       w_entry;

    assign w_tick_en = switch && ((r_state_q == C_ST_WAIT) || (r_state_q == C_ST_PROMPT));
    assign w_entry   = (w_state_d != r_state_q);

    reflex_tick_gen #(
        .TICK_CYCLES (TICK_CYCLES)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (w_tick_en),
        .clr   (w_entry),
        .tick  (w_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q <= C_ST_IDLE;
        end else begin
            r_state_q <= w_state_d;
        end
    end

    // Key judgement is tested before the tick-driven exits, so a press wins a tie.
    always_comb begin
        w_state_d = r_state_q;
        case (r_state_q)
            C_ST_IDLE, C_ST_DONE: begin
                if (start) w_state_d = C_ST_WAIT;
            end
            C_ST_WAIT: begin
                if (switch) begin
                    if (|key)                       w_state_d = C_ST_CHECK;
                    else if (r_ticks_q == C_WAIT_T) w_state_d = C_ST_PROMPT;
                end
            end
            C_ST_PROMPT: begin
                if (switch && ((|key) || (r_ticks_q == C_RESP_T))) w_state_d = C_ST_CHECK;
            end
            C_ST_CHECK: begin
                if (switch) begin
                    w_state_d = ((r_wrong_q >= C_MAX_W) || (r_round_q >= C_MAX_R)) ? C_ST_DONE
                                                                                   : C_ST_WAIT;
                end
            end
            default: w_state_d = C_ST_IDLE;
        endcase
    end

    always_comb begin
        w_target_d = r_target_q;
        w_score_d  = r_score_q;
        w_wrong_d  = r_wrong_q;
        w_round_d  = r_round_q;
        if (w_entry) begin
            w_ticks_d = '0;
        end else if (w_tick && (r_ticks_q != '1)) begin
            w_ticks_d = r_ticks_q + 8'd1;
        end else begin
            w_ticks_d = r_ticks_q;
        end
        case (r_state_q)
            C_ST_IDLE, C_ST_DONE: begin
                if (start) begin
                    w_score_d = '0;
                    w_wrong_d = '0;
                    w_round_d = '0;
                end
            end
            C_ST_WAIT: begin
                if (switch) begin
                    if (|key) begin
                        w_wrong_d = (r_wrong_q == '1) ? r_wrong_q : r_wrong_q + 3'd1;
                    end else if (r_ticks_q == C_WAIT_T) begin
                        w_target_d = 4'b0001 << r_lfsr_q[1:0];
                    end
                end
            end
            C_ST_PROMPT: begin
                if (switch) begin
                    if ((|key) || (r_ticks_q == C_RESP_T)) begin
                        w_round_d = (r_round_q == '1) ? r_round_q : r_round_q + 5'd1;
                        if (key == r_target_q) begin
                            w_score_d = (r_score_q == '1) ? r_score_q : r_score_q + 5'd1;
                        end else begin
                            w_wrong_d = (r_wrong_q == '1) ? r_wrong_q : r_wrong_q + 3'd1;
                        end
                    end
                end
            end
            C_ST_CHECK: begin
                w_target_d = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr_q   <= C_LFSR_SEED;
            r_target_q <= '0;
            r_score_q  <= '0;
            r_wrong_q  <= '0;
            r_round_q  <= '0;
            r_ticks_q  <= '0;
        end else begin
            r_lfsr_q   <= lfsr_next(r_lfsr_q);
            r_target_q <= w_target_d;
            r_score_q  <= w_score_d;
            r_wrong_q  <= w_wrong_d;
            r_round_q  <= w_round_d;
            r_ticks_q  <= w_ticks_d;
        end
    end

    always_comb begin
        target     = (r_state_q == C_ST_PROMPT) ? r_target_q : 4'b0000;
        prompt_on  = (r_state_q == C_ST_PROMPT);
        game_over  = (r_state_q == C_ST_DONE);
        score      = r_score_q;
        wrong_time = r_wrong_q;
        round      = r_round_q;
    end

endmodule

`default_nettype wire

// File: tb/tb_reflex_round_ctrl.sv
// ============================================================================
// Module   : tb_reflex_round_ctrl
// Brief    : Scoreboard bench for reflex_round_ctrl with a short tick period.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_reflex_round_ctrl;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       switch = 1'b1;
    logic       start  = 1'b0;
    logic [3:0] key    = 4'b0000;
    logic [3:0] target;
    logic       prompt_on;
    logic [4:0] score;
    logic [2:0] wrong_time;
    logic [4:0] round;
    logic       game_over;

    reflex_round_ctrl #(
        .TICK_CYCLES (4),
        .WAIT_TICKS  (2),
        .RESP_TICKS  (1),
        .MAX_ROUNDS  (15),
        .MAX_WRONG   (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .switch     (switch),
        .start      (start),
        .key        (key),
        .target     (target),
        .prompt_on  (prompt_on),
        .score      (score),
        .wrong_time (wrong_time),
        .round      (round),
        .game_over  (game_over)
    );

    always #5 clk = ~clk;

    // tm=1 marks a prompt snapshot whose target comes from the LFSR model
    typedef struct packed {
        logic [3:0] tgt;
        logic       tm;
        logic       pr;
        logic [4:0] sc;
        logic [2:0] wr;
        logic [4:0] rd;
        logic       go;
    } snap_t;

    snap_t exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;
    int    sc = 0, wr = 0, rd = 0;
    logic  mon_en = 1'b0;
    snap_t last;

    logic [7:0] m_lfsr, m_prev;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_lfsr <= 8'hA5;
            m_prev <= 8'hA5;
        end else begin
            m_prev <= m_lfsr;
            m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
        end
    end

    function automatic snap_t sample();
        return {target, 1'b0, prompt_on, score, wrong_time, round, game_over};
    endfunction

    // Monitor: every change of the output tuple consumes one expected snapshot
    initial begin
        snap_t cur, e;
        string nm;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                cur = sample();
                if (cur != last) begin
                    last = cur;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_change got tgt=%b pr=%b sc=%0d wr=%0d rd=%0d go=%b",
                                 cur.tgt, cur.pr, cur.sc, cur.wr, cur.rd, cur.go);
                    end else begin
                        e  = exp_q.pop_front();
                        nm = name_q.pop_front();
                        if (e.tm) begin
                            e.tgt = 4'b0001 << m_prev[1:0];
                            e.tm  = 1'b0;
                        end
                        if (cur != e) begin
                            errors++;
                            $display("FAIL %s got tgt=%b pr=%b sc=%0d wr=%0d rd=%0d go=%b expected tgt=%b pr=%b sc=%0d wr=%0d rd=%0d go=%b",
                                     nm, cur.tgt, cur.pr, cur.sc, cur.wr, cur.rd, cur.go,
                                     e.tgt, e.pr, e.sc, e.wr, e.rd, e.go);
                        end
                    end
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input string n, input logic pr, input logic go);
        snap_t s;
        s.tgt = 4'b0000;
        s.tm  = pr;
        s.pr  = pr;
        s.sc  = 5'(sc);
        s.wr  = 3'(wr);
        s.rd  = 5'(rd);
        s.go  = go;
        exp_q.push_back(s);
        name_q.push_back(n);
    endtask

    task automatic check_int(input string n, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", n, act, req);
        end
    endtask

    task automatic pulse_key(input logic [3:0] k);
        key = k;
        step();
        key = 4'b0000;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_prompt(output int lat);
        lat = 0;
        do begin
            step();
            lat++;
        end while (!prompt_on && lat < 60);
        if (!prompt_on) begin
            checks++;
            errors++;
            $display("FAIL prompt_wait got prompt_on=0 expected 1 within 60 cycles");
        end
    endtask

    task automatic wait_off(output int lat);
        lat = 0;
        do begin
            step();
            lat++;
        end while (prompt_on && lat < 60);
        if (prompt_on) begin
            checks++;
            errors++;
            $display("FAIL prompt_end got prompt_on=1 expected 0 within 60 cycles");
        end
    endtask

    task automatic drain(input string n);
        int w = 0;
        while (exp_q.size() != 0 && w < 60) begin
            step();
            w++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s got %0d pending snapshots expected 0", n, exp_q.size());
            exp_q.delete();
            name_q.delete();
        end
    endtask

    // Waits for the prompt, then presses the lit lane after `dly` further cycles
    task automatic hit_round(input string n, input int dly, input logic good);
        int         lat;
        logic [3:0] t;
        push({n, "_prompt"}, 1'b1, 1'b0);
        wait_prompt(lat);
        t = 4'b0001 << m_prev[1:0];
        repeat (dly) step();
        rd++;
        if (good) sc++;
        else      wr++;
        push({n, "_judge"}, 1'b0, 1'b0);
        if (rd >= 15 || wr >= 3) push({n, "_done"}, 1'b0, 1'b1);
        pulse_key(good ? t : ~t);
        drain({n, "_drain"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         lat;
        logic [3:0] t;

        repeat (3) @(negedge clk);
        check_int("reset_state", int'(sample()), 0);
        step();
        rst_n  = 1'b1;
        last   = sample();
        mon_en = 1'b1;

        // First game: prompt latency, then a timeout
        push("first_prompt", 1'b1, 1'b0);
        pulse_start();
        wait_prompt(lat);
        check_int("first_prompt_latency", lat + 1, 10);
        wr = 1; rd = 1;
        push("timeout", 1'b0, 1'b0);
        wait_off(lat);
        check_int("timeout_latency", lat, 5);
        drain("timeout_drain");

        hit_round("correct1", 0, 1'b1);

        // Early presses in WAIT end the game at the third mistake
        repeat (3) step();
        wr = 2;
        push("early1", 1'b0, 1'b0);
        pulse_key(4'b0010);
        drain("early1_drain");
        repeat (3) step();
        wr = 3;
        push("early2", 1'b0, 1'b0);
        push("early_done", 1'b0, 1'b1);
        pulse_key(4'b1000);
        drain("early2_drain");
        pulse_key(4'b0001);
        pulse_key(4'b1111);
        repeat (5) step();
        check_int("done_holds_game_over", int'(game_over), 1);

        sc = 0; wr = 0; rd = 0;
        push("restart1", 1'b0, 1'b0);
        pulse_start();
        drain("restart1_drain");

        for (int i = 0; i < 15; i++) hit_round("full_game", 0, 1'b1);
        check_int("full_round", int'(round), 15);
        check_int("full_score", int'(score), 15);
        check_int("full_wrong", int'(wrong_time), 0);

        sc = 0; wr = 0; rd = 0;
        push("restart2", 1'b0, 1'b0);
        pulse_start();
        drain("restart2_drain");

        // Presses on the tick cycle and on the timeout cycle both count as correct
        hit_round("key_on_tick", 3, 1'b1);
        hit_round("key_on_timeout", 4, 1'b1);
        hit_round("multi_bit_wrong", 1, 1'b0);

        // Pause mid-PROMPT
        push("pause_prompt", 1'b1, 1'b0);
        wait_prompt(lat);
        t = 4'b0001 << m_prev[1:0];
        step();
        switch = 1'b0;
        for (int i = 0; i < 10; i++) begin
            pulse_key(t);
            pulse_key(~t);
        end
        check_int("pause_target", int'(target), int'(t));
        check_int("pause_prompt_on", int'(prompt_on), 1);
        check_int("pause_round", int'(round), rd);
        wr++; rd++;
        push("resume_timeout", 1'b0, 1'b0);
        switch = 1'b1;
        wait_off(lat);
        check_int("resume_window", lat, 4);
        drain("resume_drain");

        // Asynchronous reset during PROMPT
        push("reset_prompt", 1'b1, 1'b0);
        wait_prompt(lat);
        sc = 0; wr = 0; rd = 0;
        push("reset_clear", 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check_int("async_reset_outputs", int'(sample()), 0);
        drain("reset_drain");
        step();
        rst_n = 1'b1;
        repeat (5) step();
        check_int("idle_after_reset", int'(prompt_on), 0);
        drain("final_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
